rx78_keyboard: RTL
==================

Name: rx78_keyboard

Overview:
- Keyboard matrix front-end for the RX-78 core.
- Converts MiSTer-style `ps2_key` events into a 9-row × 8-column key matrix.
- Serves the Z80 I/O port 0xF4: a write selects the row, a read returns that row's columns.
- Sits directly upstream of the core's I/O read mux; its `io_dout` replaces the constant 0 currently returned for 0xF4.

Parameters:
- NUM_ROWS, 9: number of matrix rows (row indices 0..NUM_ROWS-1).
- ALL_ROWS_SEL, 4'hF: row-select code that returns the OR of all rows.

Ports:
- clk  in  1  system clock (same clock as the CPU)
- reset_n  in  1  asynchronous active-low reset
- ps2_key  in  11  [10] toggle per event, [9] pressed, [8] extended (E0), [7:0] scancode
- kbd_clear  in  1  synchronous release-all request (e.g. OSD open)
- io_sel  in  1  CPU I/O cycle addressing port 0xF4
- io_wr  in  1  one-cycle write strobe, qualified by io_sel
- io_din  in  8  CPU write data
- io_dout  out  8  selected row's column bits, active-high (1 = key down)
- key_any  out  1  registered OR of all matrix bits

Behaviour:
- Reset (async, reset_n=0):
  - matrix all 0; row_sel=0; io_dout=8'h00; key_any=0.
  - Pipeline valids 0; armed=0; toggle_q=0.
- Event detect (stage A):
  - First clk edge after reset: toggle_q <= ps2_key[10], armed <= 1, no event generated. This prevents a spurious event from a stale toggle.
  - When armed and ps2_key[10] != toggle_q:
    - ev_valid <= 1 for one cycle.
    - ev_pressed, ev_ext, ev_code latched.
    - toggle_q updated.
- Map (stage B):
  - Registered lookup of {ev_ext, ev_code} through rx78_keymap.
  - Produces map_valid, map_row[3:0], map_col[2:0], map_pressed.
  - Unmapped codes give map_valid=0 and the event is dropped.
- Matrix update (stage C):
  - When map_valid: matrix[map_row][map_col] <= map_pressed.
  - Idempotent: a repeated make leaves the bit 1; a break for a key not down leaves it 0.
- Latency:
  - Toggle change sampled at edge N → matrix bit changes at edge N+2.
  - io_dout reflects the change at edge N+3.
  - key_any reflects the change at edge N+3.
- kbd_clear:
  - Clears the whole matrix at the next edge and flushes stage B.
  - If a stage-C update coincides with kbd_clear, clear wins.
- Row select:
  - io_sel & io_wr → row_sel <= io_din[3:0] at that edge.
  - io_din[7:4] is ignored.
- Read path, io_dout registered every cycle (independent of io_sel):
  - row_sel < NUM_ROWS → matrix[row_sel].
  - row_sel == ALL_ROWS_SEL → OR of all rows.
  - Any other value → 8'h00.
- Simultaneous row-select write and matrix update:
  - Both take effect.
  - io_dout on the following edge uses the new row_sel and the updated matrix.
- Event burst:
  - Back-to-back toggles on consecutive cycles are each processed; the pipeline accepts one event per cycle with no stall.
  - MiSTer event spacing guarantees no loss.
- Reset mid-operation: in-flight events are discarded and no matrix bit survives.
- Widths: map_row is 4 bits, so rows 9..14 are never produced by the keymap.

Decomposition:
- Package rx78_kbd_pkg holds:
  - NUM_ROWS and ALL_ROWS_SEL.
  - The keymap entry type {valid, row[3:0], col[2:0]}.
  - Named constants for mapped keys, including:
    - A = scancode 0x1C → row 2 col 1
    - Enter = 0x5A → row 7 col 0
    - Up arrow = E0 0x75 → row 8 col 1
    - Left shift = 0x12 → row 8 col 6
- One sub-module: rx78_keymap, a combinational case table of {ext, code[7:0]} → entry. The parent registers its output in stage B.

Test Plan:
1. Press and row read:
   - After reset, write 0x02 to port 0xF4 (io_sel=1, io_wr=1, io_din=8'h02).
   - Then flip ps2_key[10] with pressed=1, ext=0, code=0x1C.
   - Required: io_dout == 8'h02 exactly 3 edges after the toggle sample; key_any == 1 on the same edge.
   - A matching break event returns io_dout to 8'h00.
2. Extended key and all-rows read:
   - Press E0 0x75 and 0x5A; select row 8 → io_dout == 8'h02.
   - Select row 7 → io_dout == 8'h01.
   - Select 0xF → io_dout == 8'h03.
   - Select 0x9 → io_dout == 8'h00.
3. Unmapped code and stale toggle:
   - Toggle with code 0x00 → no matrix change, io_dout stays 8'h00, key_any stays 0.
   - Hold ps2_key[10]=1 through reset release → no event generated.
4. Clear priority:
   - Hold A and Shift down.
   - Assert kbd_clear on the same edge as a stage-C update for Enter.
   - Required: all rows == 8'h00 and key_any == 0 two edges later.
5. Burst:
   - Four toggles on consecutive cycles: A down, Enter down, A up, Up down.
   - Required final state: row 2 == 8'h00, row 7 == 8'h01, row 8 == 8'h02.
6. Async reset mid-pipeline:
   - Pulse reset_n low one cycle after a toggle.
   - Required: io_dout == 8'h00 immediately, row_sel == 0, and the event is never applied.

Source files
------------

// File: rtl/rx78_kbd_pkg.sv
// Shared definitions for the RX-78 keyboard matrix front-end.
package rx78_kbd_pkg;

  localparam int unsigned NUM_ROWS     = 9;
  localparam logic [3:0]  ALL_ROWS_SEL = 4'hF;
  localparam logic [3:0]  ROW_LIMIT    = 4'(NUM_ROWS);

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
  } keymap_entry_t;

  function automatic keymap_entry_t map_entry(input logic [3:0] row, input logic [2:0] col);
    keymap_entry_t e;
    e.valid = 1'b1;
    e.row   = row;
    e.col   = col;
    return e;
  endfunction

  // {ext, scancode} keys
  localparam logic [8:0] SC_A      = 9'h01C;
  localparam logic [8:0] SC_B      = 9'h032;
  localparam logic [8:0] SC_C      = 9'h021;
  localparam logic [8:0] SC_SPACE  = 9'h029;
  localparam logic [8:0] SC_ENTER  = 9'h05A;
  localparam logic [8:0] SC_UP     = 9'h175;
  localparam logic [8:0] SC_DOWN   = 9'h172;
  localparam logic [8:0] SC_LSHIFT = 9'h012;
  localparam logic [8:0] SC_RSHIFT = 9'h059;

  localparam keymap_entry_t MAP_A      = map_entry(4'd2, 3'd1);
  localparam keymap_entry_t MAP_B      = map_entry(4'd2, 3'd2);
  localparam keymap_entry_t MAP_C      = map_entry(4'd2, 3'd3);
  localparam keymap_entry_t MAP_SPACE  = map_entry(4'd7, 3'd4);
  localparam keymap_entry_t MAP_ENTER  = map_entry(4'd7, 3'd0);
  localparam keymap_entry_t MAP_UP     = map_entry(4'd8, 3'd1);
  localparam keymap_entry_t MAP_DOWN   = map_entry(4'd8, 3'd0);
  localparam keymap_entry_t MAP_SHIFT  = map_entry(4'd8, 3'd6);

endpackage

// File: rtl/rx78_keyboard_if.sv
// CPU I/O port 0xF4 bus: row-select write and column read.
interface rx78_keyboard_if;
  logic       io_sel;
  logic       io_wr;
  logic [7:0] io_din;
  logic [7:0] io_dout;

  modport master (output io_sel, output io_wr, output io_din, input io_dout);
  modport slave  (input io_sel, input io_wr, input io_din, output io_dout);
endinterface

// File: rtl/rx78_keymap.sv
// Combinational {ext, scancode} -> matrix position table.
module rx78_keymap
  import rx78_kbd_pkg::*;
(
  input  logic          ext_i,
  input  logic [7:0]    code_i,
  output keymap_entry_t entry_o
);

  // Unlisted codes fall through to an invalid entry.
  always_comb begin
    entry_o = '0;
    case ({ext_i, code_i})
      SC_A:      entry_o = MAP_A;
      SC_B:      entry_o = MAP_B;
      SC_C:      entry_o = MAP_C;
      SC_SPACE:  entry_o = MAP_SPACE;
      SC_ENTER:  entry_o = MAP_ENTER;
      SC_UP:     entry_o = MAP_UP;
      SC_DOWN:   entry_o = MAP_DOWN;
      SC_LSHIFT: entry_o = MAP_SHIFT;
      SC_RSHIFT: entry_o = MAP_SHIFT;
      default:   entry_o = '0;
    endcase
  end

endmodule

// File: rtl/rx78_keyboard.sv
// PS/2 event -> 9x8 key matrix, read back through Z80 port 0xF4.
module rx78_keyboard
  import rx78_kbd_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [10:0]      ps2_key,
  input  logic             kbd_clear,
  rx78_keyboard_if.slave   bus,
  output logic             key_any
);

  logic       armed_q, armed_d;
  logic       toggle_q, toggle_d;
  logic       ev_valid_q, ev_valid_d;
  logic       ev_pressed_q, ev_pressed_d;
  logic       ev_ext_q, ev_ext_d;
  logic [7:0] ev_code_q, ev_code_d;

  logic       map_valid_q, map_valid_d;
  logic [3:0] map_row_q, map_row_d;
  logic [2:0] map_col_q, map_col_d;
  logic       map_pressed_q, map_pressed_d;

  logic [NUM_ROWS-1:0][7:0] matrix_q, matrix_d;
  logic [3:0] row_sel_q, row_sel_d;
  logic [7:0] io_dout_q, io_dout_d;
  logic       key_any_q, key_any_d;
  logic [7:0] any_row;

  keymap_entry_t entry;
  logic          unused_din;

  assign unused_din  = ^bus.io_din[7:4];
  assign bus.io_dout = io_dout_q;
  assign key_any     = key_any_q;

  rx78_keymap u_keymap (
    .ext_i   (ev_ext_q),
    .code_i  (ev_code_q),
    .entry_o (entry)
  );

  // Stage A: the first edge after reset only captures the toggle, so a stale level is not an event.
  always_comb begin
    armed_d      = 1'b1;
    toggle_d     = ps2_key[10];
    ev_valid_d   = armed_q && (ps2_key[10] != toggle_q);
    ev_pressed_d = ev_pressed_q;
    ev_ext_d     = ev_ext_q;
    ev_code_d    = ev_code_q;
    if (ev_valid_d) begin
      ev_pressed_d = ps2_key[9];
      ev_ext_d     = ps2_key[8];
      ev_code_d    = ps2_key[7:0];
    end
  end

  // Stage B: register the keymap lookup; kbd_clear flushes it.
  always_comb begin
    map_valid_d   = ev_valid_q && entry.valid && !kbd_clear;
    map_row_d     = entry.row;
    map_col_d     = entry.col;
    map_pressed_d = ev_pressed_q;
  end

  // Stage C plus row select: kbd_clear overrides a coincident key update.
  always_comb begin
    matrix_d = matrix_q;
    if (kbd_clear) begin
      matrix_d = '0;
    end else if (map_valid_q && (map_row_q < ROW_LIMIT)) begin
      matrix_d[map_row_q][map_col_q] = map_pressed_q;
    end
    row_sel_d = row_sel_q;
    if (bus.io_sel && bus.io_wr) begin
      row_sel_d = bus.io_din[3:0];
    end
  end

  // Read path: registered every cycle from the current row select and matrix.
  always_comb begin
    any_row = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      any_row = any_row | matrix_q[r[3:0]];
    end
    key_any_d = |any_row;
    if (row_sel_q < ROW_LIMIT) begin
      io_dout_d = matrix_q[row_sel_q];
    end else if (row_sel_q == ALL_ROWS_SEL) begin
      io_dout_d = any_row;
    end else begin
      io_dout_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q       <= 1'b0;
      toggle_q      <= 1'b0;
      ev_valid_q    <= 1'b0;
      ev_pressed_q  <= 1'b0;
      ev_ext_q      <= 1'b0;
      ev_code_q     <= '0;
      map_valid_q   <= 1'b0;
      map_row_q     <= '0;
      map_col_q     <= '0;
      map_pressed_q <= 1'b0;
      matrix_q      <= '0;
      row_sel_q     <= '0;
      io_dout_q     <= '0;
      key_any_q     <= 1'b0;
    end else begin
      armed_q       <= armed_d;
      toggle_q      <= toggle_d;
      ev_valid_q    <= ev_valid_d;
      ev_pressed_q  <= ev_pressed_d;
      ev_ext_q      <= ev_ext_d;
      ev_code_q     <= ev_code_d;
      map_valid_q   <= map_valid_d;
      map_row_q     <= map_row_d;
      map_col_q     <= map_col_d;
      map_pressed_q <= map_pressed_d;
      matrix_q      <= matrix_d;
      row_sel_q     <= row_sel_d;
      io_dout_q     <= io_dout_d;
      key_any_q     <= key_any_d;
    end
  end

endmodule
